// File: rtl/rv_imm_pkg.sv
// Shared format codes, opcode constants and skid-buffer state encoding
// for the immediate-decode stage.
package rv_imm_pkg;

    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } imm_type_t;

    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_JAL     = 7'b1101111;
    localparam logic [6:0] OP_JALR    = 7'b1100111;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_LOAD    = 7'b0000011;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_OPIMM   = 7'b0010011;
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM  = 7'b1110011;
    localparam logic [6:0] OP_FENCE   = 7'b0001111;
    localparam logic [6:0] OP_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OP_OP32    = 7'b0111011;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PIPE  = 2'd1,
        ST_SKID  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/imm_extract.sv
// Combinational format classification and sign-extended immediate
// extraction for one 32-bit RISC-V instruction.
module imm_extract
    import rv_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output imm_type_t       imm_type,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [6:0]  opcode;
    logic [31:0] raw;

    assign opcode = instr[6:0];

    always_comb begin
        imm_type = R_TYPE;
        illegal  = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC:                                imm_type = U_TYPE;
            OP_JAL:                                          imm_type = J_TYPE;
            OP_BRANCH:                                       imm_type = B_TYPE;
            OP_STORE:                                        imm_type = S_TYPE;
            OP_JALR, OP_LOAD, OP_OPIMM, OP_SYSTEM, OP_FENCE: imm_type = I_TYPE;
            OP_OP:                                           imm_type = R_TYPE;
            OP_OPIMM32: begin
                if (XLEN == 64) imm_type = I_TYPE;
                else            illegal  = 1'b1;
            end
            OP_OP32: begin
                if (XLEN != 64) illegal = 1'b1;
            end
            default:                                         illegal  = 1'b1;
        endcase
        // Compressed/reserved encodings are rejected regardless of opcode.
        if (illegal || instr[1:0] != 2'b11) begin
            illegal  = 1'b1;
            imm_type = R_TYPE;
        end
    end

    always_comb begin
        raw = 32'd0;
        case (imm_type)
            I_TYPE:  raw = {{20{instr[31]}}, instr[31:20]};
            S_TYPE:  raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            B_TYPE:  raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            U_TYPE:  raw = {instr[31:12], 12'd0};
            J_TYPE:  raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: raw = 32'd0;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign imm = {{(XLEN-32){raw[31]}}, raw};
        end else begin : g_narrow
            assign imm = raw;
        end
    endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decode ahead of a 2-entry skid buffer
// so that in_ready comes straight from a flop.
module imm_decode_stage
    import rv_imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [2:0]      out_type,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    imm_type_t       ext_type;
    logic [XLEN-1:0] ext_imm;
    logic            ext_illegal;
    logic [XLEN-1:0] ext_target;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr    (in_instr),
        .imm_type (ext_type),
        .imm      (ext_imm),
        .illegal  (ext_illegal)
    );

    assign ext_target = in_pc + ext_imm;

    buf_state_t      state_reg, state_next;
    logic            in_ready_reg;
    logic            accept, take;
    logic            load_out_in, load_out_skid, load_skid;

    logic [31:0]     out_instr_reg,   skid_instr_reg;
    logic [XLEN-1:0] out_pc_reg,      skid_pc_reg;
    logic [2:0]      out_type_reg,    skid_type_reg;
    logic [XLEN-1:0] out_imm_reg,     skid_imm_reg;
    logic [XLEN-1:0] out_target_reg,  skid_target_reg;
    logic            out_illegal_reg, skid_illegal_reg;

    assign accept = in_valid & in_ready_reg;
    assign take   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_EMPTY;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != ST_SKID);
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_EMPTY: if (accept) state_next = ST_PIPE;
            ST_PIPE: begin
                if (accept && !take)      state_next = ST_SKID;
                else if (!accept && take) state_next = ST_EMPTY;
            end
            ST_SKID:  if (take) state_next = ST_PIPE;
            default:  state_next = ST_EMPTY;
        endcase
        if (flush) state_next = ST_EMPTY;
    end

    // Register-load strobes; a flush suppresses every load so nothing stale survives.
    always_comb begin
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (!flush) begin
            case (state_reg)
                ST_EMPTY: load_out_in = accept;
                ST_PIPE: begin
                    if (accept && take) load_out_in = 1'b1;
                    else if (accept)    load_skid   = 1'b1;
                end
                ST_SKID:  load_out_skid = take;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_instr_reg    <= '0;
            out_pc_reg       <= '0;
            out_type_reg     <= '0;
            out_imm_reg      <= '0;
            out_target_reg   <= '0;
            out_illegal_reg  <= 1'b0;
            skid_instr_reg   <= '0;
            skid_pc_reg      <= '0;
            skid_type_reg    <= '0;
            skid_imm_reg     <= '0;
            skid_target_reg  <= '0;
            skid_illegal_reg <= 1'b0;
        end else begin
            if (load_out_in) begin
                out_instr_reg   <= in_instr;
                out_pc_reg      <= in_pc;
                out_type_reg    <= ext_type;
                out_imm_reg     <= ext_imm;
                out_target_reg  <= ext_target;
                out_illegal_reg <= ext_illegal;
            end else if (load_out_skid) begin
                out_instr_reg   <= skid_instr_reg;
                out_pc_reg      <= skid_pc_reg;
                out_type_reg    <= skid_type_reg;
                out_imm_reg     <= skid_imm_reg;
                out_target_reg  <= skid_target_reg;
                out_illegal_reg <= skid_illegal_reg;
            end
            if (load_skid) begin
                skid_instr_reg   <= in_instr;
                skid_pc_reg      <= in_pc;
                skid_type_reg    <= ext_type;
                skid_imm_reg     <= ext_imm;
                skid_target_reg  <= ext_target;
                skid_illegal_reg <= ext_illegal;
            end
        end
    end

    assign in_ready    = in_ready_reg;
    assign out_valid   = (state_reg != ST_EMPTY);
    assign out_instr   = out_instr_reg;
    assign out_pc      = out_pc_reg;
    assign out_type    = out_type_reg;
    assign out_imm     = out_imm_reg;
    assign out_target  = out_target_reg;
    assign out_illegal = out_illegal_reg;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed-vector bench for imm_decode_stage at XLEN=32 and XLEN=64.
module tb_imm_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic [63:0] in_pc64;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] out_instr, out_pc, out_imm, out_target;
    logic [2:0]  out_type;

    logic        in_ready64, out_valid64, out_illegal64;
    logic [31:0] out_instr64;
    logic [63:0] out_pc64, out_imm64, out_target64;
    logic [2:0]  out_type64;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    assign in_pc64 = {32'd0, in_pc};

    imm_decode_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_type(out_type),
        .out_imm(out_imm), .out_target(out_target), .out_illegal(out_illegal)
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_instr(out_instr64), .out_pc(out_pc64), .out_type(out_type64),
        .out_imm(out_imm64), .out_target(out_target64), .out_illegal(out_illegal64)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [2:0]  typ;
        logic [31:0] imm;
        logic        ill;
        logic [31:0] tgt;
        logic [2:0]  typ64;
        logic [63:0] imm64;
        logic        ill64;
    } vec_t;

    vec_t vecs[11];

    task automatic decode_one(input vec_t v);
        in_valid  = 1'b1;
        in_instr  = v.instr;
        in_pc     = v.pc;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check({v.tag, ".valid"},   {63'd0, out_valid}, 64'd1);
        check({v.tag, ".type"},    {61'd0, out_type},  {61'd0, v.typ});
        check({v.tag, ".imm"},     {32'd0, out_imm},   {32'd0, v.imm});
        check({v.tag, ".target"},  {32'd0, out_target}, {32'd0, v.tgt});
        check({v.tag, ".illegal"}, {63'd0, out_illegal}, {63'd0, v.ill});
        check({v.tag, ".type64"},  {61'd0, out_type64}, {61'd0, v.typ64});
        check({v.tag, ".imm64"},   out_imm64, v.imm64);
        check({v.tag, ".tgt64"},   out_target64, {32'd0, v.pc} + v.imm64);
        check({v.tag, ".ill64"},   {63'd0, out_illegal64}, {63'd0, v.ill64});
        step();
        check({v.tag, ".drained"}, {63'd0, out_valid}, 64'd0);
    endtask

    // Leaves the stage in SKID holding beats 0xA0000013 (out) and 0xB0000013 (skid).
    task automatic fill_skid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hA000_0013;
        in_pc     = 32'h0000_0A00;
        step();
        in_instr  = 32'hB000_0013;
        in_pc     = 32'h0000_0B00;
        step();
    endtask

    initial begin
        vecs[0]  = '{"jal_pos",  32'h001000EF, 32'h1000, 3'd5, 32'h00000800, 1'b0, 32'h00001800, 3'd5, 64'h800, 1'b0};
        vecs[1]  = '{"jal_neg",  32'hFFDFF06F, 32'h0100, 3'd5, 32'hFFFFFFFC, 1'b0, 32'h000000FC, 3'd5, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        vecs[2]  = '{"beq_neg",  32'hFE000EE3, 32'h0200, 3'd3, 32'hFFFFFFFC, 1'b0, 32'h000001FC, 3'd3, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        vecs[3]  = '{"store",    32'h7E002FA3, 32'h0000, 3'd2, 32'h000007FF, 1'b0, 32'h000007FF, 3'd2, 64'h7FF, 1'b0};
        vecs[4]  = '{"lui",      32'h800000B7, 32'h0040, 3'd4, 32'h80000000, 1'b0, 32'h80000040, 3'd4, 64'hFFFFFFFF_80000000, 1'b0};
        vecs[5]  = '{"zero_ill", 32'h00000000, 32'h0044, 3'd0, 32'h00000000, 1'b1, 32'h00000044, 3'd0, 64'h0, 1'b1};
        vecs[6]  = '{"addi_m1",  32'hFFF00093, 32'h0008, 3'd1, 32'hFFFFFFFF, 1'b0, 32'h00000007, 3'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        vecs[7]  = '{"addiw",    32'hFFF0009B, 32'h0010, 3'd0, 32'h00000000, 1'b1, 32'h00000010, 3'd1, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        vecs[8]  = '{"add_r",    32'h002081B3, 32'h0020, 3'd0, 32'h00000000, 1'b0, 32'h00000020, 3'd0, 64'h0, 1'b0};
        vecs[9]  = '{"ecall",    32'h00000073, 32'h0030, 3'd1, 32'h00000000, 1'b0, 32'h00000030, 3'd1, 64'h0, 1'b0};
        vecs[10] = '{"low_bits", 32'h001000ED, 32'h0050, 3'd0, 32'h00000000, 1'b1, 32'h00000050, 3'd0, 64'h0, 1'b1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_pc = 32'h0;
        step(); step();
        rst = 1'b0;
        check("rst.out_valid",  {63'd0, out_valid}, 64'd0);
        check("rst.in_ready",   {63'd0, in_ready},  64'd1);
        check("rst.out_instr",  {32'd0, out_instr}, 64'd0);
        check("rst.out_pc",     {32'd0, out_pc},    64'd0);
        check("rst.out_type",   {61'd0, out_type},  64'd0);
        check("rst.out_imm",    {32'd0, out_imm},   64'd0);
        check("rst.out_target", {32'd0, out_target}, 64'd0);
        check("rst.illegal",    {63'd0, out_illegal}, 64'd0);

        foreach (vecs[i]) decode_one(vecs[i]);

        // Backpressure: A on outputs, B in skid, C held upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'hA000_0013; in_pc = 32'h0A00;
        step();
        check("bp.a_out",       {32'd0, out_instr}, 64'hA000_0013);
        check("bp.ready_pipe",  {63'd0, in_ready},  64'd1);
        in_instr  = 32'hB000_0013; in_pc = 32'h0B00;
        step();
        check("bp.ready_skid",  {63'd0, in_ready},  64'd0);
        check("bp.a_held",      {32'd0, out_instr}, 64'hA000_0013);
        in_instr  = 32'hC000_0013; in_pc = 32'h0C00;
        step();
        check("bp.a_held2",     {32'd0, out_instr}, 64'hA000_0013);
        check("bp.a_imm",       {32'd0, out_imm},   64'hFFFF_FA00);
        check("bp.still_full",  {63'd0, in_ready},  64'd0);
        out_ready = 1'b1;
        step();
        check("bp.b_out",       {32'd0, out_instr}, 64'hB000_0013);
        check("bp.b_pc",        {32'd0, out_pc},    64'h0000_0B00);
        step();
        check("bp.c_out",       {32'd0, out_instr}, 64'hC000_0013);
        check("bp.c_valid",     {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        step();
        check("bp.drained",     {63'd0, out_valid}, 64'd0);

        // Sustained streaming with out_ready high.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_instr = 32'h0010_0093 + (32'(k) << 20);
            in_pc    = 32'h2000 + 32'(k) * 4;
            step();
            check($sformatf("stream%0d.instr", k), {32'd0, out_instr}, {32'd0, 32'h0010_0093 + (32'(k) << 20)});
            check($sformatf("stream%0d.imm", k),   {32'd0, out_imm},   64'(k + 1));
            check($sformatf("stream%0d.ready", k), {63'd0, in_ready},  64'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream.drained", {63'd0, out_valid}, 64'd0);

        // Flush while in SKID with a new beat offered.
        fill_skid();
        check("fl.in_skid",     {63'd0, in_ready},  64'd0);
        in_instr = 32'hD000_0013; in_pc = 32'h0D00;
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl.out_valid",   {63'd0, out_valid}, 64'd0);
        check("fl.in_ready",    {63'd0, in_ready},  64'd1);
        out_ready = 1'b1;
        step();
        check("fl.no_capture",  {63'd0, out_valid}, 64'd0);
        step();
        check("fl.no_stale",    {63'd0, out_valid}, 64'd0);

        // Reset while in SKID with a new beat offered.
        fill_skid();
        check("rs.in_skid",     {63'd0, in_ready},  64'd0);
        in_instr = 32'hE000_0013; in_pc = 32'h0E00;
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("rs.out_valid",   {63'd0, out_valid}, 64'd0);
        check("rs.in_ready",    {63'd0, in_ready},  64'd1);
        check("rs.out_instr",   {32'd0, out_instr}, 64'd0);
        out_ready = 1'b1;
        step();
        check("rs.no_capture",  {63'd0, out_valid}, 64'd0);
        step();
        check("rs.no_stale",    {63'd0, out_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
